rvj1_writeback: RTL and testbench
=================================

RVJ1_WRITEBACK -- requirements
Module: rvj1_writeback

Interface
REQ-001 SHALL have parameter DEPTH, default 2, ALU result queue depth; legal values 2, 4, 8.
REQ-002 SHALL have port clk_i, input, 1, core clock; only clock, rising edge.
REQ-003 SHALL have port rstn_i, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port alu_valid_i, input, 1, ALU result offered.
REQ-005 SHALL have port alu_ready_o, output, 1, queue can accept.
REQ-006 SHALL have port alu_dest_i, input, RALEN, ALU destination register.
REQ-007 SHALL have port alu_data_i, input, XLEN, ALU result.
REQ-008 SHALL have port lsu_valid_i, input, 1, load result offered; always accepted, no ready.
REQ-009 SHALL have port lsu_dest_i, input, RALEN, load destination register.
REQ-010 SHALL have port lsu_data_i, input, XLEN, load data.
REQ-011 SHALL have port rf_we_o, output, 1, regfile write enable.
REQ-012 SHALL have port rf_addr_o, output, RALEN, regfile write address.
REQ-013 SHALL have port rf_data_o, output, XLEN, regfile write data.
REQ-014 SHALL have port busy_o, output, 1, queue non-empty.

Function
REQ-015 SHALL accept an ALU beat when alu_valid_i && alu_ready_o at the rising edge.
REQ-016 SHALL drive alu_ready_o = (count != DEPTH), from registered state only; no same-cycle pass-through when full.
REQ-017 SHALL discard accepted ALU beats with alu_dest_i == 0; they are not queued.
REQ-018 SHALL queue non-zero ALU beats FIFO-ordered; read/write pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-019 SHALL arbitrate the write port each cycle with fixed priority: LSU first, then queue head.
REQ-020 SHALL register the winner: rf_we_o/rf_addr_o/rf_data_o valid the cycle after selection (1-cycle latency); rf_we_o low when no winner.
REQ-021 SHALL pop the queue head only in a cycle with lsu_valid_i low.
REQ-022 SHALL allow simultaneous push and pop; count unchanged.
REQ-023 SHALL treat LSU as younger than every queued entry: on lsu_valid_i with lsu_dest_i != 0, queued entries with matching dest are squashed (skipped when reaching the head, no write).
REQ-024 SHALL accept LSU beats with lsu_dest_i == 0 without asserting rf_we_o and without squashing.
REQ-025 SHALL NOT squash an ALU beat accepted in the same cycle as an LSU beat to the same register; the ALU beat is younger.
REQ-026 SHALL drive busy_o = (count != 0).
REQ-027 SHALL keep rf_addr_o/rf_data_o stable when rf_we_o is low.

Reset
REQ-028 SHALL on rstn_i low immediately clear count, pointers, squash flags, rf_we_o=0, rf_addr_o=0, rf_data_o=0, busy_o=0, alu_ready_o=1.
REQ-029 SHALL drop all queued entries on reset mid-operation; no write issued in the first cycle after release.

Configuration
REQ-030 SHALL, with RVJ1_WB_FWD_EN defined, add ports fwd_addr_i (input, RALEN), fwd_hit_o (output, 1), fwd_data_o (output, XLEN).
REQ-031 SHALL, with RVJ1_WB_FWD_EN, combinationally return youngest non-squashed value for fwd_addr_i among registered output (rf_we_o) and queued entries, queued entries being younger; fwd_hit_o=0, fwd_data_o=0 when fwd_addr_i==0 or no match.
REQ-032 SHALL, without RVJ1_WB_FWD_EN, omit these ports and the lookup logic entirely.

Verification
REQ-033 SHALL cover: ALU beat x5=0x0000_1234, LSU idle -> rf_we_o=1, rf_addr_o=5, rf_data_o=0x1234 exactly one cycle later.
REQ-034 SHALL cover: DEPTH=2, LSU valid 4 cycles, ALU offers x1,x2,x3 -> alu_ready_o low after 2 accepts; x1,x2,x3 written in order after LSU ends.
REQ-035 SHALL cover: queue holds x7=0xAAAA, LSU x7=0xBBBB -> only 0xBBBB written to x7; queued entry squashed.
REQ-036 SHALL cover: ALU x0=0xFFFF and LSU x0=0x1 -> rf_we_o never asserted.
REQ-037 SHALL cover: rstn_i low with 2 queued entries -> outputs reset at once, no writes after release, alu_ready_o=1.
REQ-038 SHALL cover (RVJ1_WB_FWD_EN): queued x9=0x10 then x9=0x20, fwd_addr_i=9 -> fwd_hit_o=1, fwd_data_o=0x20.

Source files
------------

// File: rtl/rvj1_writeback.sv
// Writeback stage: merges LSU load results and a small ALU result queue onto one regfile write port.
// Optional forwarding lookup port enabled by defining RVJ1_WB_FWD_EN.
module rvj1_writeback #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32,
   parameter int RALEN = 5
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             alu_valid_i,
   output logic             alu_ready_o,
   input  logic [RALEN-1:0] alu_dest_i,
   input  logic [XLEN-1:0]  alu_data_i,
   input  logic             lsu_valid_i,
   input  logic [RALEN-1:0] lsu_dest_i,
   input  logic [XLEN-1:0]  lsu_data_i,
   output logic             rf_we_o,
   output logic [RALEN-1:0] rf_addr_o,
   output logic [XLEN-1:0]  rf_data_o,
   output logic             busy_o
`ifdef RVJ1_WB_FWD_EN
   ,
   input  logic [RALEN-1:0] fwd_addr_i,
   output logic             fwd_hit_o,
   output logic [XLEN-1:0]  fwd_data_o
`endif
);

   localparam int PTRW = $clog2(DEPTH);
   localparam int CNTW = PTRW + 1;

   logic [RALEN-1:0] dest_q [DEPTH];
   logic [XLEN-1:0]  data_q [DEPTH];
   logic [DEPTH-1:0] squash_q;
   logic [PTRW-1:0]  rd_ptr;
   logic [PTRW-1:0]  wr_ptr;
   logic [CNTW-1:0]  count;

   logic             head_valid;
   logic             alu_take;
   logic             lsu_write;
   logic             pop;
   logic             bypass;
   logic             push;
   logic             head_live;
   logic [DEPTH-1:0] occupied;

   assign alu_ready_o = (count != CNTW'(DEPTH));
   assign busy_o      = (count != '0);
   assign head_valid  = (count != '0);
   assign alu_take    = alu_valid_i && alu_ready_o && (alu_dest_i != '0);
   assign lsu_write   = lsu_valid_i && (lsu_dest_i != '0);
   assign pop         = head_valid && !lsu_valid_i;
   // An ALU beat arriving at an empty queue with the LSU idle goes straight to the write port.
   assign bypass      = alu_take && !head_valid && !lsu_valid_i;
   assign push        = alu_take && !bypass;
   assign head_live   = pop && !squash_q[rd_ptr];

   always_comb begin
      occupied = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occupied[i] = (CNTW'(PTRW'(PTRW'(i) - rd_ptr)) < count);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         squash_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTRW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTRW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase
         // The load is younger than anything already queued, so older writes to its register die.
         for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_ptr == PTRW'(i))) begin
               squash_q[i] <= 1'b0;
            end else if (lsu_write && occupied[i] && (dest_q[i] == lsu_dest_i)) begin
               squash_q[i] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         dest_q[wr_ptr] <= alu_dest_i;
         data_q[wr_ptr] <= alu_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rf_we_o   <= 1'b0;
         rf_addr_o <= '0;
         rf_data_o <= '0;
      end else if (lsu_write) begin
         rf_we_o   <= 1'b1;
         rf_addr_o <= lsu_dest_i;
         rf_data_o <= lsu_data_i;
      end else if (head_live) begin
         rf_we_o   <= 1'b1;
         rf_addr_o <= dest_q[rd_ptr];
         rf_data_o <= data_q[rd_ptr];
      end else if (bypass) begin
         rf_we_o   <= 1'b1;
         rf_addr_o <= alu_dest_i;
         rf_data_o <= alu_data_i;
      end else begin
         rf_we_o   <= 1'b0;
      end
   end

`ifdef RVJ1_WB_FWD_EN
   // Scan oldest to youngest so the last match wins; the registered output is older than the queue.
   always_comb begin
      fwd_hit_o  = 1'b0;
      fwd_data_o = '0;
      if (fwd_addr_i != '0) begin
         if (rf_we_o && (rf_addr_o == fwd_addr_i)) begin
            fwd_hit_o  = 1'b1;
            fwd_data_o = rf_data_o;
         end
         for (int k = 0; k < DEPTH; k++) begin
            if ((CNTW'(k) < count) && !squash_q[rd_ptr + PTRW'(k)]
                && (dest_q[rd_ptr + PTRW'(k)] == fwd_addr_i)) begin
               fwd_hit_o  = 1'b1;
               fwd_data_o = data_q[rd_ptr + PTRW'(k)];
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_rvj1_writeback.sv
// Directed, table-driven bench for rvj1_writeback (DEPTH=2), plus reset and forwarding sequences.
module tb_rvj1_writeback;

   localparam int DEPTH = 2;
   localparam int XLEN  = 32;
   localparam int RALEN = 5;

   logic             clk = 1'b0;
   logic             rstn;
   logic             alu_valid;
   logic             alu_ready;
   logic [RALEN-1:0] alu_dest;
   logic [XLEN-1:0]  alu_data;
   logic             lsu_valid;
   logic [RALEN-1:0] lsu_dest;
   logic [XLEN-1:0]  lsu_data;
   logic             rf_we;
   logic [RALEN-1:0] rf_addr;
   logic [XLEN-1:0]  rf_data;
   logic             busy;
`ifdef RVJ1_WB_FWD_EN
   logic [RALEN-1:0] fwd_addr;
   logic             fwd_hit;
   logic [XLEN-1:0]  fwd_data;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rvj1_writeback #(.DEPTH(DEPTH), .XLEN(XLEN), .RALEN(RALEN)) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .alu_valid_i (alu_valid),
      .alu_ready_o (alu_ready),
      .alu_dest_i  (alu_dest),
      .alu_data_i  (alu_data),
      .lsu_valid_i (lsu_valid),
      .lsu_dest_i  (lsu_dest),
      .lsu_data_i  (lsu_data),
      .rf_we_o     (rf_we),
      .rf_addr_o   (rf_addr),
      .rf_data_o   (rf_data),
      .busy_o      (busy)
`ifdef RVJ1_WB_FWD_EN
      ,
      .fwd_addr_i  (fwd_addr),
      .fwd_hit_o   (fwd_hit),
      .fwd_data_o  (fwd_data)
`endif
   );

   typedef struct {
      logic        av;
      logic [4:0]  ad;
      logic [31:0] adata;
      logic        lv;
      logic [4:0]  ld;
      logic [31:0] ldata;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        ready;
      logic        busy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkVec(input logic av, input logic [4:0] ad, input logic [31:0] adata,
                                  input logic lv, input logic [4:0] ld, input logic [31:0] ldata,
                                  input logic we, input logic [4:0] addr, input logic [31:0] data,
                                  input logic ready, input logic bsy);
      vec_t v;
      v.av = av; v.ad = ad; v.adata = adata;
      v.lv = lv; v.ld = ld; v.ldata = ldata;
      v.we = we; v.addr = addr; v.data = data;
      v.ready = ready; v.busy = bsy;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] ad, input logic [31:0] adata,
                        input logic lv, input logic [4:0] ld, input logic [31:0] ldata);
      alu_valid = av; alu_dest = ad; alu_data = adata;
      lsu_valid = lv; lsu_dest = ld; lsu_data = ldata;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v);
      drive(v.av, v.ad, v.adata, v.lv, v.ld, v.ldata);
      step();
   endtask

   initial begin
      // Expected values are the outputs observed just after the edge that consumed the inputs.
      vecs.push_back(mkVec(1, 5, 32'h1234, 0, 0, 0,         1, 5,  32'h1234, 1, 0));
      vecs.push_back(mkVec(0, 0, 0,        0, 0, 0,         0, 5,  32'h1234, 1, 0));
      vecs.push_back(mkVec(1, 1, 32'h101,  1, 10, 32'h20A, 1, 10, 32'h20A,  1, 1));
      vecs.push_back(mkVec(1, 2, 32'h102,  1, 11, 32'h20B, 1, 11, 32'h20B,  0, 1));
      vecs.push_back(mkVec(1, 3, 32'h103,  1, 12, 32'h20C, 1, 12, 32'h20C,  0, 1));
      vecs.push_back(mkVec(1, 3, 32'h103,  1, 13, 32'h20D, 1, 13, 32'h20D,  0, 1));
      vecs.push_back(mkVec(1, 3, 32'h103,  0, 0, 0,         1, 1,  32'h101,  1, 1));
      vecs.push_back(mkVec(1, 3, 32'h103,  0, 0, 0,         1, 2,  32'h102,  1, 1));
      vecs.push_back(mkVec(0, 0, 0,        0, 0, 0,         1, 3,  32'h103,  1, 0));
      vecs.push_back(mkVec(0, 0, 0,        0, 0, 0,         0, 3,  32'h103,  1, 0));
      vecs.push_back(mkVec(1, 7, 32'hAAAA, 1, 4, 32'h44,   1, 4,  32'h44,   1, 1));
      vecs.push_back(mkVec(0, 0, 0,        1, 7, 32'hBBBB, 1, 7,  32'hBBBB, 1, 1));
      vecs.push_back(mkVec(0, 0, 0,        0, 0, 0,         0, 7,  32'hBBBB, 1, 0));
      vecs.push_back(mkVec(0, 0, 0,        0, 0, 0,         0, 7,  32'hBBBB, 1, 0));
      vecs.push_back(mkVec(1, 8, 32'h888,  1, 8, 32'h999,  1, 8,  32'h999,  1, 1));
      vecs.push_back(mkVec(0, 0, 0,        0, 0, 0,         1, 8,  32'h888,  1, 0));
      vecs.push_back(mkVec(1, 0, 32'hFFFF, 1, 0, 32'h1,    0, 8,  32'h888,  1, 0));
      vecs.push_back(mkVec(1, 0, 32'hFFFF, 0, 0, 0,         0, 8,  32'h888,  1, 0));

      rstn = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
`ifdef RVJ1_WB_FWD_EN
      fwd_addr = '0;
`endif
      #2 rstn = 1'b0;
      #1;
      checkOutput("reset we",    32'(rf_we),     0);
      checkOutput("reset addr",  32'(rf_addr),   0);
      checkOutput("reset data",  rf_data,        0);
      checkOutput("reset busy",  32'(busy),      0);
      checkOutput("reset ready", 32'(alu_ready), 1);
      step();
      rstn = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("v%0d we", i),    32'(rf_we),     32'(vecs[i].we));
         checkOutput($sformatf("v%0d addr", i),  32'(rf_addr),   32'(vecs[i].addr));
         checkOutput($sformatf("v%0d data", i),  rf_data,        vecs[i].data);
         checkOutput($sformatf("v%0d ready", i), 32'(alu_ready), 32'(vecs[i].ready));
         checkOutput($sformatf("v%0d busy", i),  32'(busy),      32'(vecs[i].busy));
      end

      // Reset mid-operation with two entries queued behind LSU traffic.
      drive(1, 1, 32'h111, 1, 10, 32'h310);
      step();
      drive(1, 2, 32'h222, 1, 11, 32'h311);
      step();
      checkOutput("prerst busy",  32'(busy),      1);
      checkOutput("prerst ready", 32'(alu_ready), 0);
      checkOutput("prerst we",    32'(rf_we),     1);
      drive(0, 0, 0, 0, 0, 0);
      #2 rstn = 1'b0;
      #1;
      checkOutput("midrst we",    32'(rf_we),     0);
      checkOutput("midrst addr",  32'(rf_addr),   0);
      checkOutput("midrst data",  rf_data,        0);
      checkOutput("midrst busy",  32'(busy),      0);
      checkOutput("midrst ready", 32'(alu_ready), 1);
      step();
      rstn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         checkOutput($sformatf("postrst%0d we", c),    32'(rf_we),     0);
         checkOutput($sformatf("postrst%0d busy", c),  32'(busy),      0);
         checkOutput($sformatf("postrst%0d ready", c), 32'(alu_ready), 1);
      end

`ifdef RVJ1_WB_FWD_EN
      // Two queued writes to x9; the younger one must be forwarded.
      drive(1, 9, 32'h10, 1, 4, 32'h44);
      step();
      drive(1, 9, 32'h20, 1, 4, 32'h45);
      step();
      drive(0, 0, 0, 1, 0, 0);
      fwd_addr = 5'd9;
      #1;
      checkOutput("fwd x9 hit",  32'(fwd_hit), 1);
      checkOutput("fwd x9 data", fwd_data,     32'h20);
      fwd_addr = 5'd4;
      #1;
      checkOutput("fwd x4 hit",  32'(fwd_hit), 1);
      checkOutput("fwd x4 data", fwd_data,     32'h45);
      fwd_addr = 5'd0;
      #1;
      checkOutput("fwd x0 hit",  32'(fwd_hit), 0);
      checkOutput("fwd x0 data", fwd_data,     0);
      fwd_addr = 5'd3;
      #1;
      checkOutput("fwd x3 hit",  32'(fwd_hit), 0);
      fwd_addr = 5'd0;
      drive(0, 0, 0, 0, 0, 0);
      step();
      step();
      step();
      checkOutput("fwd drain busy", 32'(busy), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
